// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, keeps up to DEPTH requests in flight to imem and returns
// instructions in order. Optional misaligned-jump flag is enabled by IFU_MISALIGN_TRAP_EN.
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
`ifdef IFU_MISALIGN_TRAP_EN
  output logic        fetch_misalign_o,
`endif
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_addr_o,
  output logic [31:0] inst_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthCnt = (CntW + 1)'(DEPTH);

  logic [31:0]     pc_q, pc_d;
  logic            epoch_q, epoch_d;
  logic [CntW-1:0] out_q, out_d, cnt_q, cnt_d;
  logic [PtrW-1:0] twr_q, twr_d, trd_q, trd_d;
  logic [PtrW-1:0] bwr_q, bwr_d, brd_q, brd_d;

  logic            tag_q   [DEPTH];
  logic [31:0]     taddr_q [DEPTH];
  logic [31:0]     baddr_q [DEPTH];
  logic [31:0]     bdata_q [DEPTH];

  logic            issue, rsp, keep, pop;
  logic [CntW:0]   used;

  assign inst_valid_o = (cnt_q != '0);
  assign inst_addr_o  = inst_valid_o ? baddr_q[brd_q] : 32'h0;
  assign inst_o       = inst_valid_o ? bdata_q[brd_q] : `INST_NOP;
  assign imem_addr_o  = pc_q;

  always_comb begin
    pop  = inst_valid_o & inst_ready_i;
    // A slot being popped this cycle counts as free, which sustains one instruction per cycle.
    used = {1'b0, out_q} + {1'b0, cnt_q} - {{CntW{1'b0}}, pop};
    imem_req_o = !rst && !jump_en_i && (used < DepthCnt);
    issue = imem_req_o & imem_gnt_i;
    // Responses with nothing outstanding belong to requests issued before a reset.
    rsp  = imem_rvalid_i && (out_q != '0);
    keep = rsp && !jump_en_i && (tag_q[trd_q] == epoch_q);

    pc_d = pc_q;
    if (jump_en_i) begin
      pc_d = {jump_addr_i[31:2], 2'b00};
    end else if (issue) begin
      pc_d = pc_q + 32'd4;
    end
    epoch_d = epoch_q ^ jump_en_i;
    out_d   = out_q + CntW'(issue) - CntW'(rsp);
    twr_d   = twr_q + PtrW'(issue);
    trd_d   = trd_q + PtrW'(rsp);

    if (jump_en_i) begin
      bwr_d = '0;
      brd_d = '0;
      cnt_d = '0;
    end else begin
      bwr_d = bwr_q + PtrW'(keep);
      brd_d = brd_q + PtrW'(pop);
      cnt_d = cnt_q + CntW'(keep) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      epoch_q <= 1'b0;
      out_q   <= '0;
      cnt_q   <= '0;
      twr_q   <= '0;
      trd_q   <= '0;
      bwr_q   <= '0;
      brd_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      twr_q   <= twr_d;
      trd_q   <= trd_d;
      bwr_q   <= bwr_d;
      brd_q   <= brd_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_q[twr_q]   <= epoch_q;
      taddr_q[twr_q] <= pc_q;
    end
    if (keep) begin
      baddr_q[bwr_q] <= taddr_q[trd_q];
      bdata_q[bwr_q] <= imem_rdata_i;
    end
  end

`ifdef IFU_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= jump_en_i && (jump_addr_i[1:0] != 2'b00);
    end
  end

  assign fetch_misalign_o = misalign_q;
`else
  logic unused_jump_lsb;
  assign unused_jump_lsb = ^jump_addr_i[1:0];
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: cycle table for the pipelined flow plus scoreboarded corner sequences,
// driven by an in-order imem model with configurable response latency.
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt = 1'b1;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        inst_valid;
  logic        ready = 1'b1;
  logic [31:0] inst_addr;
  logic [31:0] inst;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  int n_chk = 0;
  int n_fail = 0;

  ifu_fetch #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
`ifdef IFU_MISALIGN_TRAP_EN
    .fetch_misalign_o(fetch_misalign),
`endif
    .clk          (clk),
    .rst          (rst),
    .jump_en_i    (jump_en),
    .jump_addr_i  (jump_addr),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_gnt_i   (gnt),
    .imem_rvalid_i(rvalid),
    .imem_rdata_i (rdata),
    .inst_valid_o (inst_valid),
    .inst_ready_i (ready),
    .inst_addr_o  (inst_addr),
    .inst_o       (inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // imem model: grants are captured at the negedge (inputs are stable until the next edge),
  // responses return in order lat edges after the grant edge.
  typedef struct {
    logic [31:0] addr;
    longint      due;
  } pend_t;

  pend_t  mem_q[$];
  longint cyc = 0;
  int     lat = 1;
  int     n_gnt = 0;
  int     max_out = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rvalid = 1'b0;
    rdata  = 32'hDEAD_BEEF;
    if (mem_q.size() > 0 && mem_q[0].due == cyc + 1) begin
      rvalid = 1'b1;
      rdata  = mem_f(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
    if (imem_req && gnt) begin
      mem_q.push_back('{addr: imem_addr, due: cyc + 1 + longint'(lat)});
      n_gnt++;
    end
    if (mem_q.size() > max_out) max_out = mem_q.size();
  end

  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    step();
    rst = 1'b1;
    jump_en = 1'b0;
    mem_q.delete();
    step();
    rst = 1'b0;
  endtask

  // Pop expected addresses and compare against each accepted instruction (ready held high).
  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] ea;
      bit          seen;
      ea = exp_q.pop_front();
      seen = 1'b0;
      for (int w = 0; w < 40 && !seen; w++) begin
        @(negedge clk);
        seen = inst_valid;
      end
      chk("drain_valid", 32'(seen), 32'd1);
      chk("drain_addr", inst_addr, ea);
      chk("drain_inst", inst, mem_f(ea));
      step();
    end
  endtask

  typedef struct {
    bit          rst;
    bit          ready;
    bit          jump;
    logic [31:0] jaddr;
    bit          e_req;
    logic [31:0] e_iaddr;
    bit          e_valid;
    logic [31:0] e_ia;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit rdy, input bit j, input logic [31:0] ja,
                              input bit er, input logic [31:0] eia, input bit ev,
                              input logic [31:0] ea);
    vec_t v;
    v.rst = r; v.ready = rdy; v.jump = j; v.jaddr = ja;
    v.e_req = er; v.e_iaddr = eia; v.e_valid = ev; v.e_ia = ea;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[$];
    int   g0;

    // Zero-wait memory from reset: hold, resume and a redirect with one response in flight.
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 1'b0, 32'h00));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h00, 1'b0, 32'h00));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h04, 1'b0, 32'h00));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h08, 1'b1, 32'h00));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0C, 1'b1, 32'h04));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 1'b1, 32'h08));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h14, 1'b1, 32'h0C));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h14, 1'b1, 32'h0C));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h14, 1'b1, 32'h0C));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h18, 1'b1, 32'h10));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h1C, 1'b1, 32'h14));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h20, 1'b1, 32'h18));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h40, 1'b0, 32'h00));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h44, 1'b0, 32'h00));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h48, 1'b1, 32'h40));

    lat = 1;
    reset_dut();
    for (int i = 0; i < vecs.size(); i++) begin
      rst       = vecs[i].rst;
      ready     = vecs[i].ready;
      jump_en   = vecs[i].jump;
      jump_addr = vecs[i].jaddr;
      @(negedge clk);
      chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
      chk($sformatf("tbl%0d_imem_addr", i), imem_addr, vecs[i].e_iaddr);
      chk($sformatf("tbl%0d_valid", i), 32'(inst_valid), 32'(vecs[i].e_valid));
      chk($sformatf("tbl%0d_inst_addr", i), inst_addr, vecs[i].e_ia);
      chk($sformatf("tbl%0d_inst", i), inst, vecs[i].e_valid ? mem_f(vecs[i].e_ia) : `INST_NOP);
      step();
    end
    jump_en = 1'b0;

    // Hold with ready low: head stays at 0x0 and only DEPTH requests are fetched.
    ready = 1'b0;
    reset_dut();
    g0 = n_gnt;
    for (int w = 0; w < 20 && !inst_valid; w++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(inst_valid), 32'd1);
      chk("hold_addr", inst_addr, 32'h0);
      @(negedge clk);
    end
    chk("hold_fetch_count", 32'(n_gnt - g0), 32'd2);
    step();
    ready = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    drain(3);

    // Three-cycle memory latency.
    lat = 3;
    reset_dut();
    max_out = 0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    drain(3);
    chk("max_outstanding", 32'(max_out), 32'd2);

    // Jump with one response outstanding and one buffered.
    reset_dut();
    step(); step(); step(); step();
    @(negedge clk);
    chk("pre_jump_addr", inst_addr, 32'h0);
    step();
    ready = 1'b0;
    jump_en = 1'b1;
    jump_addr = 32'h100;
    @(negedge clk);
    chk("jump_cycle_req", 32'(imem_req), 32'd0);
    chk("jump_cycle_buffered", inst_addr, 32'h4);
    step();
    jump_en = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    chk("post_jump_valid", 32'(inst_valid), 32'd0);
    chk("post_jump_imem_addr", imem_addr, 32'h100);
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    drain(2);

    // Reset pulse with two requests in flight; stale responses return after reset.
    reset_dut();
    step(); step();
    rst = 1'b1;
    gnt = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_stale_valid", 32'(inst_valid), 32'd0);
      chk("rst_req_held", 32'(imem_req), 32'd1);
      chk("rst_addr_held", imem_addr, 32'h0);
      step();
    end
    gnt = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    drain(2);

    // PC wrap at the top of the address space.
    lat = 1;
    reset_dut();
    jump_en = 1'b1;
    jump_addr = 32'hFFFF_FFF8;
    step();
    jump_en = 1'b0;
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    drain(4);

    // Back-to-back jumps: only the last target survives.
    reset_dut();
    jump_en = 1'b1;
    jump_addr = 32'h300;
    step();
    jump_addr = 32'h400;
    step();
    jump_en = 1'b0;
    exp_q.push_back(32'h400); exp_q.push_back(32'h404);
    drain(2);

    // Misaligned jump target is aligned down.
    reset_dut();
    jump_en = 1'b1;
    jump_addr = 32'h202;
    step();
    jump_en = 1'b0;
    @(negedge clk);
`ifdef IFU_MISALIGN_TRAP_EN
    chk("misalign_set", 32'(fetch_misalign), 32'd1);
`endif
    step();
    @(negedge clk);
`ifdef IFU_MISALIGN_TRAP_EN
    chk("misalign_clear", 32'(fetch_misalign), 32'd0);
`endif
    exp_q.push_back(32'h200);
    drain(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
